// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: converts two raw push-button inputs into clean, mutually
// exclusive set/reset command pulses for a downstream SR flip-flop.
//
// Each button is synchronized (2 flops), debounced, and edge-detected. A
// single FSM turns accepted rising edges into a PULSE_CYCLES-wide s or r
// pulse followed by one idle GAP cycle. Simultaneous set/clear requests are
// refused and counted. Requests that arrive while a command is in progress
// are dropped.
//
// Ports:
//   clock        - rising-edge clock for all state
//   reset        - synchronous, active-low reset
//   set_btn      - raw asynchronous set request, active-high
//   clr_btn      - raw asynchronous clear request, active-high
//   s            - registered set command pulse
//   r            - registered reset command pulse
//   busy         - high whenever the FSM is not idle
//   conflict     - one-cycle pulse on a simultaneous set/clear request
//   drop         - one-cycle pulse when request(s) are discarded while busy
//   conflict_cnt - saturating (at 255) count of conflict events
module sr_cmd_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned PULSE_CYCLES    = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       set_btn,
    input  logic       clr_btn,
    output logic       s,
    output logic       r,
    output logic       busy,
    output logic       conflict,
    output logic       drop,
    output logic [7:0] conflict_cnt
);

    // The debounce counter only ever holds 0..DEBOUNCE_CYCLES-1.
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET_P = 2'd1,
        CLR_P = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Channel 0 = set, channel 1 = clear.
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    db;
    logic [1:0]    db_q;
    logic [CW-1:0] cnt [2];
    logic [1:0]    req;

    state_t        state;
    state_t        state_n;
    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_n;
    logic          conflict_n;
    logic          drop_n;

    // Synchronizers and debouncers. db flips only after the synchronized
    // input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_q  <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= {clr_btn, set_btn};
            sync2 <= sync1;
            db_q  <= db;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt[i] <= '0;
                    db[i]  <= ~db[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Only rising edges of the debounced level are requests.
    assign req = db & ~db_q;

    always_comb begin
        state_n    = state;
        pcnt_n     = pcnt;
        conflict_n = 1'b0;
        drop_n     = 1'b0;
        case (state)
            IDLE: begin
                pcnt_n = '0;
                if (req[0] && req[1]) begin
                    conflict_n = 1'b1;
                end else if (req[0]) begin
                    state_n = SET_P;
                end else if (req[1]) begin
                    state_n = CLR_P;
                end
            end
            SET_P, CLR_P: begin
                if (pcnt == PW'(PULSE_CYCLES - 1)) begin
                    state_n = GAP;
                    pcnt_n  = '0;
                end else begin
                    pcnt_n = pcnt + 1'b1;
                end
            end
            GAP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // Any number of simultaneous discarded edges gives a single drop pulse.
        if (state != IDLE && req != 2'b00) begin
            drop_n = 1'b1;
        end
    end

    // Outputs are registered from the next state so s/r come straight off
    // flops and line up with the state they describe.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            pcnt         <= '0;
            s            <= 1'b0;
            r            <= 1'b0;
            busy         <= 1'b0;
            conflict     <= 1'b0;
            drop         <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            state    <= state_n;
            pcnt     <= pcnt_n;
            s        <= (state_n == SET_P);
            r        <= (state_n == CLR_P);
            busy     <= (state_n != IDLE);
            conflict <= conflict_n;
            drop     <= drop_n;
            if (conflict_n && conflict_cnt != 8'hFF) begin
                conflict_cnt <= conflict_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Bench for sr_cmd_gen: two instances (PULSE_CYCLES 2 and 3, shared
// stimulus) checked every cycle against a timestamp-based reference model,
// plus directed literal checks and randomized button stimulus.
module tb_sr_cmd_gen;

    localparam int D  = 4;
    localparam int PA = 2;
    localparam int PB = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic set_btn = 1'b0;
    logic clr_btn = 1'b0;

    logic s_a, r_a, busy_a, conf_a, drop_a;
    logic s_b, r_b, busy_b, conf_b, drop_b;
    logic [7:0] cc_a, cc_b;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    sr_cmd_gen #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(PA)) dut_a (
        .clock(clock), .reset(reset), .set_btn(set_btn), .clr_btn(clr_btn),
        .s(s_a), .r(r_a), .busy(busy_a), .conflict(conf_a), .drop(drop_a),
        .conflict_cnt(cc_a)
    );

    sr_cmd_gen #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(PB)) dut_b (
        .clock(clock), .reset(reset), .set_btn(set_btn), .clr_btn(clr_btn),
        .s(s_b), .r(r_b), .busy(busy_b), .conflict(conf_b), .drop(drop_b),
        .conflict_cnt(cc_b)
    );

    int edge_n = -1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // ---------------- reference model ----------------
    // Debounce tracked per channel as a run length of disagreeing samples;
    // command FSM tracked as timestamps: pulse start edge, kind, and the
    // first edge at which a new request can be accepted again.
    bit m_sy1 [2];
    bit m_sy2 [2];
    bit m_db  [2];
    bit m_dbp [2];
    int m_run [2];
    int pw    [2];
    int start [2];
    int kind  [2];   // 0 none, 1 set, 2 clear
    int idle_from [2];
    int m_cc  [2];
    bit e_s [2], e_r [2], e_busy [2], e_conf [2], e_drop [2];
    bit rst_edge = 1'b0;
    bit model_valid = 1'b0;

    initial begin
        pw[0] = PA;
        pw[1] = PB;
    end

    always @(posedge clock) begin
        bit sreq, creq, pre_idle;
        edge_n++;
        rst_edge = !reset;
        if (!reset) begin
            model_valid = 1'b1;
            for (int c = 0; c < 2; c++) begin
                m_sy1[c] = 0; m_sy2[c] = 0; m_db[c] = 0; m_dbp[c] = 0; m_run[c] = 0;
            end
            for (int i = 0; i < 2; i++) begin
                kind[i] = 0; idle_from[i] = edge_n + 1; m_cc[i] = 0;
                e_s[i] = 0; e_r[i] = 0; e_busy[i] = 0; e_conf[i] = 0; e_drop[i] = 0;
            end
        end else begin
            sreq = m_db[0] && !m_dbp[0];
            creq = m_db[1] && !m_dbp[1];
            for (int i = 0; i < 2; i++) begin
                pre_idle  = (edge_n >= idle_from[i]);
                e_conf[i] = 0;
                e_drop[i] = 0;
                if (pre_idle && sreq && creq) begin
                    e_conf[i] = 1;
                    if (m_cc[i] < 255) m_cc[i]++;
                end else if (pre_idle && (sreq || creq)) begin
                    start[i]     = edge_n;
                    kind[i]      = sreq ? 1 : 2;
                    idle_from[i] = edge_n + pw[i] + 2;
                end else if (!pre_idle && (sreq || creq)) begin
                    e_drop[i] = 1;
                end
                e_s[i]    = (kind[i] == 1) && edge_n >= start[i] && edge_n <= start[i] + pw[i] - 1;
                e_r[i]    = (kind[i] == 2) && edge_n >= start[i] && edge_n <= start[i] + pw[i] - 1;
                e_busy[i] = (kind[i] != 0) && edge_n >= start[i] && edge_n <= start[i] + pw[i];
            end
            for (int c = 0; c < 2; c++) begin
                m_dbp[c] = m_db[c];
                if (m_sy2[c] != m_db[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D) begin
                        m_db[c]  = !m_db[c];
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_sy2[c] = m_sy1[c];
                m_sy1[c] = (c == 0) ? set_btn : clr_btn;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int run_s [2] = '{0, 0};
    int run_r [2] = '{0, 0};

    always @(negedge clock) begin
        logic as [2], ar [2], ab [2], acf [2], adr [2];
        int acc [2];
        as[0] = s_a; ar[0] = r_a; ab[0] = busy_a; acf[0] = conf_a; adr[0] = drop_a; acc[0] = int'(cc_a);
        as[1] = s_b; ar[1] = r_b; ab[1] = busy_b; acf[1] = conf_b; adr[1] = drop_b; acc[1] = int'(cc_b);
        if (model_valid) begin
            for (int i = 0; i < 2; i++) begin
                string tag;
                tag = (i == 0) ? "a" : "b";
                chk({"s_", tag}, int'(as[i]), int'(e_s[i]));
                chk({"r_", tag}, int'(ar[i]), int'(e_r[i]));
                chk({"busy_", tag}, int'(ab[i]), int'(e_busy[i]));
                chk({"conflict_", tag}, int'(acf[i]), int'(e_conf[i]));
                chk({"drop_", tag}, int'(adr[i]), int'(e_drop[i]));
                chk({"conflict_cnt_", tag}, acc[i], m_cc[i]);
                chk({"s_and_r_", tag}, int'(as[i] & ar[i]), 0);
                // Pulse widths; pulses cut short by reset are exempt.
                if (as[i]) run_s[i]++;
                else if (run_s[i] > 0) begin
                    if (!rst_edge) chk({"s_width_", tag}, run_s[i], pw[i]);
                    run_s[i] = 0;
                end
                if (ar[i]) run_r[i]++;
                else if (run_r[i] > 0) begin
                    if (!rst_edge) chk({"r_width_", tag}, run_r[i], pw[i]);
                    run_r[i] = 0;
                end
            end
        end
    end

    // ---------------- stimulus and literal checks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Leaves reset released just after an edge; the next edge is "edge 0".
    task automatic do_reset();
        reset = 1'b0; set_btn = 1'b0; clr_btn = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
    endtask

    initial begin
        int hs, hc;

        // Held set, DEBOUNCE 4: s_a high after edges 6,7; busy_a 6..8.
        do_reset();
        set_btn = 1'b1;
        for (int e = 0; e <= 9; e++) begin
            tick();
            chk("lit_hold_s_a", int'(s_a), int'(e == 6 || e == 7));
            chk("lit_hold_busy_a", int'(busy_a), int'(e >= 6 && e <= 8));
            chk("lit_hold_s_b", int'(s_b), int'(e >= 6 && e <= 8));
            chk("lit_hold_busy_b", int'(busy_b), int'(e >= 6 && e <= 9));
        end
        // Still held: no second pulse.
        repeat (20) begin
            tick();
            chk("lit_held_no_repeat", int'(s_a | s_b), 0);
        end

        // Reset in first SET_P cycle; button still held.
        do_reset();
        set_btn = 1'b1;
        repeat (7) tick();
        chk("lit_rst_pre_s_b", int'(s_b), 1);
        reset = 1'b0;
        tick();
        chk("lit_rst_s_b", int'(s_b), 0);
        chk("lit_rst_busy_b", int'(busy_b), 0);
        chk("lit_rst_busy_a", int'(busy_a), 0);
        reset = 1'b1;
        for (int e = 8; e <= 14; e++) begin
            tick();
            chk("lit_rst_relaunch_s_b", int'(s_b), int'(e == 14));
            chk("lit_rst_relaunch_s_a", int'(s_a), int'(e == 14));
        end

        // Glitch of 3 cycles is ignored.
        do_reset();
        repeat (2) tick();
        set_btn = 1'b1;
        repeat (3) tick();
        set_btn = 1'b0;
        repeat (20) begin
            tick();
            chk("lit_glitch_s_a", int'(s_a), 0);
            chk("lit_glitch_busy_a", int'(busy_a), 0);
        end

        // Simultaneous press -> conflict, then saturate the counter.
        do_reset();
        set_btn = 1'b1; clr_btn = 1'b1;
        repeat (7) tick();
        chk("lit_conflict_a", int'(conf_a), 1);
        chk("lit_conflict_cnt_a", int'(cc_a), 1);
        chk("lit_conflict_sr_a", int'(s_a | r_a), 0);
        chk("lit_conflict_cnt_b", int'(cc_b), 1);
        tick();
        chk("lit_conflict_one_cycle", int'(conf_a), 0);
        set_btn = 1'b0; clr_btn = 1'b0;
        repeat (8) tick();
        for (int k = 1; k < 300; k++) begin
            set_btn = 1'b1; clr_btn = 1'b1;
            repeat (8) tick();
            set_btn = 1'b0; clr_btn = 1'b0;
            repeat (8) tick();
        end
        chk("lit_conflict_sat_a", int'(cc_a), 255);
        chk("lit_conflict_sat_b", int'(cc_b), 255);

        // Clear request lands during a set pulse -> drop, r stays 0.
        do_reset();
        set_btn = 1'b1;
        tick();
        clr_btn = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            chk("lit_drop_b", int'(drop_b), int'(e == 7));
            chk("lit_drop_r_b", int'(r_b), 0);
            chk("lit_drop_s_b", int'(s_b), int'(e >= 6 && e <= 8));
            chk("lit_drop_a", int'(drop_a), int'(e == 7));
            chk("lit_drop_s_a", int'(s_a), int'(e >= 6 && e <= 7));
        end
        set_btn = 1'b0; clr_btn = 1'b0;
        repeat (10) tick();

        // Randomized buttons with occasional resets.
        hs = 0; hc = 0;
        for (int n = 0; n < 20000; n++) begin
            if (hs == 0) begin
                set_btn = ~set_btn;
                hs = $urandom_range(1, 14);
                if ($urandom_range(0, 3) == 0) begin
                    clr_btn = set_btn;
                    hc = hs;
                end
            end else hs--;
            if (hc == 0) begin
                clr_btn = ~clr_btn;
                hc = $urandom_range(1, 14);
            end else hc--;
            reset = ($urandom_range(0, 999) != 0);
            tick();
        end
        reset = 1'b1;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
